// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte-lane word RAM, one-cycle formatted loads,
// alignment fault reporting and a tohost MMIO register for simulation halt.
module dmem_ctrl #(
    parameter int          DEPTH_WORDS = 4096,
    parameter string       INIT_FILE   = "",
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_F000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmemAddr,
    input  logic [31:0] dmemWdata,
    input  logic [2:0]  dmemSize,
    input  logic        dmemWen,
    input  logic        dmemRen,
    output logic [31:0] dmemRdata,
    output logic        misalignFault,
    output logic [31:0] faultAddr,
    output logic        tohostValid,
    output logic [31:0] tohostData,
    output logic        halt
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] wordIdx;
    logic             isByte, isHalf, isWord, legalCode, misaligned;
    logic             tohostWord, tohostHit;
    logic             storeFault, loadFault, storeOk, loadOk, anyFault;
    logic             ramWe, tohostWe;
    logic [3:0]       byteEn;
    logic [31:0]      wdataLanes;
    logic [31:0]      ramRdata;
    logic             loadValid, loadTohost;
    logic [2:0]       loadSize;
    logic [1:0]       loadOff;
    logic [31:0]      srcWord;
    logic [7:0]       laneByte;
    logic [15:0]      laneHalf;

    assign wordIdx    = dmemAddr[IDX_W+1:2];
    assign isByte     = (dmemSize[1:0] == 2'b00);
    assign isHalf     = (dmemSize[1:0] == 2'b01);
    assign isWord     = (dmemSize[1:0] == 2'b10);
    assign legalCode  = (dmemSize inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign misaligned = (isHalf && dmemAddr[0]) || (isWord && (dmemAddr[1:0] != 2'b00));
    assign tohostWord = (dmemAddr[31:2] == TOHOST_ADDR[31:2]);
    assign tohostHit  = (dmemAddr == TOHOST_ADDR);

    // Unsigned codes are load-only; partial stores into the tohost word are rejected.
    assign storeFault = !legalCode || dmemSize[2] || misaligned || (tohostWord && !isWord);
    assign loadFault  = !legalCode || misaligned;
    assign storeOk    = !rst && dmemWen && !storeFault;
    assign loadOk     = !rst && dmemRen && !dmemWen && !loadFault;
    assign anyFault   = !rst && (dmemWen ? storeFault : (dmemRen && loadFault));
    assign ramWe      = storeOk && !tohostHit;
    assign tohostWe   = storeOk && tohostHit;

    // Lane enables and replicated store data for byte/half/word stores.
    always_comb begin
        byteEn     = 4'b1111;
        wdataLanes = dmemWdata;
        if (isByte) begin
            byteEn     = 4'b0001 << dmemAddr[1:0];
            wdataLanes = {4{dmemWdata[7:0]}};
        end else if (isHalf) begin
            byteEn     = dmemAddr[1] ? 4'b1100 : 4'b0011;
            wdataLanes = {2{dmemWdata[15:0]}};
        end
    end

    // Single-port RAM: byte-masked write, synchronous read (never both in one cycle).
    always_ff @(posedge clk) begin
        if (ramWe) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[wordIdx][8*i +: 8] <= wdataLanes[8*i +: 8];
            end
        end
        if (loadOk) ramRdata <= mem[wordIdx];
    end

    // Load side-band, fault reporting and tohost state.
    always_ff @(posedge clk) begin
        if (rst) begin
            loadValid     <= 1'b0;
            loadTohost    <= 1'b0;
            loadSize      <= 3'b000;
            loadOff       <= 2'b00;
            misalignFault <= 1'b0;
            faultAddr     <= 32'h0;
            tohostValid   <= 1'b0;
            tohostData    <= 32'h0;
            halt          <= 1'b0;
        end else begin
            loadValid     <= loadOk;
            loadTohost    <= tohostHit && isWord;
            loadSize      <= dmemSize;
            loadOff       <= dmemAddr[1:0];
            misalignFault <= anyFault;
            tohostValid   <= tohostWe;
            if (anyFault) faultAddr <= dmemAddr;
            if (tohostWe) begin
                tohostData <= dmemWdata;
                if (dmemWdata[0]) halt <= 1'b1;
            end
        end
    end

    always_comb begin
        srcWord  = loadTohost ? tohostData : ramRdata;
        laneHalf = loadOff[1] ? srcWord[31:16] : srcWord[15:0];
        case (loadOff)
            2'd0:    laneByte = srcWord[7:0];
            2'd1:    laneByte = srcWord[15:8];
            2'd2:    laneByte = srcWord[23:16];
            default: laneByte = srcWord[31:24];
        endcase
        dmemRdata = 32'h0;
        if (loadValid) begin
            case (loadSize)
                SZ_B:    dmemRdata = {{24{laneByte[7]}}, laneByte};
                SZ_BU:   dmemRdata = {24'h0, laneByte};
                SZ_H:    dmemRdata = {{16{laneHalf[15]}}, laneHalf};
                SZ_HU:   dmemRdata = {16'h0, laneHalf};
                default: dmemRdata = srcWord;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, a short halt
// sequence, then random traffic against a byte-level memory model.
module tb_dmem_ctrl;
    localparam int          DEPTH     = 4096;
    localparam int          MEM_BYTES = DEPTH * 4;
    localparam logic [31:0] TOHOST    = 32'h0000_F000;

    localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100, SZ_HU = 3'b101, SZ_BAD = 3'b011;

    // {rst, wen, ren}
    localparam logic [2:0] ID = 3'b000, LD = 3'b001, ST = 3'b010, SL = 3'b011, RS = 3'b101;
    // {fault, tohostValid, halt}
    localparam logic [2:0] F0 = 3'b000, FF = 3'b100, TV = 3'b010, HH = 3'b001;

    logic        clk = 1'b0;
    logic        rst, dmemWen, dmemRen;
    logic [31:0] dmemAddr, dmemWdata;
    logic [2:0]  dmemSize;
    logic [31:0] dmemRdata, faultAddr, tohostData;
    logic        misalignFault, tohostValid, halt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .INIT_FILE(""), .TOHOST_ADDR(TOHOST)) dut (
        .clk(clk), .rst(rst), .dmemAddr(dmemAddr), .dmemWdata(dmemWdata),
        .dmemSize(dmemSize), .dmemWen(dmemWen), .dmemRen(dmemRen),
        .dmemRdata(dmemRdata), .misalignFault(misalignFault), .faultAddr(faultAddr),
        .tohostValid(tohostValid), .tohostData(tohostData), .halt(halt)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic [2:0]  expFlags;
        logic [31:0] expFaultAddr;
        logic [31:0] expTohost;
    } vec_t;

    vec_t vecs[$];

    // Reference model: byte-addressed memory plus architectural registers.
    logic [7:0]  mb [int];
    logic [31:0] mTohost = 32'h0, mFaultAddr = 32'h0;
    logic        mHalt = 1'b0;
    logic [31:0] eRdata;
    logic        eFault, eTv;

    function automatic vec_t mk(logic [2:0] op, logic [2:0] sz, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] rd, logic [2:0] fl, logic [31:0] fa, logic [31:0] td);
        vec_t v;
        v.op = op; v.size = sz; v.addr = a; v.wdata = wd;
        v.expRdata = rd; v.expFlags = fl; v.expFaultAddr = fa; v.expTohost = td;
        return v;
    endfunction

    task automatic modelStep(input logic r, input logic w, input logic rd, input logic [2:0] sz,
                             input logic [31:0] a, input logic [31:0] wd);
        int          n;
        int          key;
        logic        illegal, mis, fault;
        logic [31:0] v;
        eRdata = 32'h0; eFault = 1'b0; eTv = 1'b0; fault = 1'b0;
        if (r) begin
            mTohost = 32'h0; mHalt = 1'b0; mFaultAddr = 32'h0;
            return;
        end
        illegal = !(sz inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU});
        n   = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
        mis = (a % 32'(n)) != 32'h0;
        if (w) begin
            fault = illegal || (sz == SZ_BU) || (sz == SZ_HU) || mis
                    || (n < 4 && (a / 4) == (TOHOST / 4));
            if (!fault) begin
                if (a == TOHOST) begin
                    mTohost = wd; eTv = 1'b1;
                    if (wd[0]) mHalt = 1'b1;
                end else begin
                    for (int i = 0; i < n; i++) begin
                        key = int'((a + 32'(i)) % 32'(MEM_BYTES));
                        mb[key] = wd[8*i +: 8];
                    end
                end
            end
        end else if (rd) begin
            fault = illegal || mis;
            if (!fault) begin
                v = 32'h0;
                if (n == 4 && a == TOHOST) v = mTohost;
                else begin
                    for (int i = 0; i < n; i++) begin
                        key = int'((a + 32'(i)) % 32'(MEM_BYTES));
                        v[8*i +: 8] = mb[key];
                    end
                end
                if (sz[2] == 1'b0 && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                eRdata = v;
            end
        end
        if (fault) begin
            eFault = 1'b1; mFaultAddr = a;
        end
    endtask

    task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input logic [31:0] rd, input logic f, input logic [31:0] fa,
                               input logic tv, input logic [31:0] td, input logic h);
        checkOne("rdata", dmemRdata, rd);
        checkOne("fault", {31'h0, misalignFault}, {31'h0, f});
        checkOne("faultAddr", faultAddr, fa);
        checkOne("tohostValid", {31'h0, tohostValid}, {31'h0, tv});
        checkOne("tohostData", tohostData, td);
        checkOne("halt", {31'h0, halt}, {31'h0, h});
    endtask

    // Drives one request at the falling edge and returns at the next falling edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] sz,
                                 input logic [31:0] a, input logic [31:0] wd);
        rst = op[2]; dmemWen = op[1]; dmemRen = op[0];
        dmemSize = sz; dmemAddr = a; dmemWdata = wd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic modelCycle(input logic [2:0] op, input logic [2:0] sz,
                              input logic [31:0] a, input logic [31:0] wd);
        modelStep(op[2], op[1], op[0], sz, a, wd);
        applyStimulus(op, sz, a, wd);
        checkOutput(eRdata, eFault, mFaultAddr, eTv, mTohost, mHalt);
    endtask

    initial begin
        rst = 1'b1; dmemWen = 1'b0; dmemRen = 1'b0;
        dmemSize = SZ_W; dmemAddr = 32'h0; dmemWdata = 32'h0;
        @(negedge clk);

        modelCycle(RS, SZ_W, 32'h0, 32'h0);
        modelCycle(RS, SZ_W, 32'h0, 32'h0);

        for (int a = 0; a < 256; a += 4)
            modelCycle(ST, SZ_W, 32'(a), 32'hA5C3_0000 | 32'(a));
        modelCycle(ST, SZ_W, 32'h3000, 32'hA5C3_3000);

        vecs.push_back(mk(ST, SZ_W,   32'h10,   32'hDEADBEEF, 32'h0,        F0,       32'h0,    32'h0));
        vecs.push_back(mk(LD, SZ_W,   32'h10,   32'h0,        32'hDEADBEEF, F0,       32'h0,    32'h0));
        vecs.push_back(mk(ST, SZ_B,   32'h21,   32'h80,       32'h0,        F0,       32'h0,    32'h0));
        vecs.push_back(mk(LD, SZ_B,   32'h21,   32'h0,        32'hFFFFFF80, F0,       32'h0,    32'h0));
        vecs.push_back(mk(LD, SZ_BU,  32'h21,   32'h0,        32'h00000080, F0,       32'h0,    32'h0));
        vecs.push_back(mk(LD, SZ_W,   32'h20,   32'h0,        32'hA5C38020, F0,       32'h0,    32'h0));
        vecs.push_back(mk(ST, SZ_H,   32'h32,   32'h8001,     32'h0,        F0,       32'h0,    32'h0));
        vecs.push_back(mk(LD, SZ_H,   32'h32,   32'h0,        32'hFFFF8001, F0,       32'h0,    32'h0));
        vecs.push_back(mk(LD, SZ_HU,  32'h32,   32'h0,        32'h00008001, F0,       32'h0,    32'h0));
        vecs.push_back(mk(LD, SZ_W,   32'h30,   32'h0,        32'h80010030, F0,       32'h0,    32'h0));
        vecs.push_back(mk(ST, SZ_W,   32'h41,   32'hCAFEF00D, 32'h0,        FF,       32'h41,   32'h0));
        vecs.push_back(mk(LD, SZ_W,   32'h40,   32'h0,        32'hA5C30040, F0,       32'h41,   32'h0));
        vecs.push_back(mk(LD, SZ_H,   32'h43,   32'h0,        32'h0,        FF,       32'h43,   32'h0));
        vecs.push_back(mk(LD, SZ_BAD, 32'h44,   32'h0,        32'h0,        FF,       32'h44,   32'h0));
        vecs.push_back(mk(ST, SZ_BU,  32'h45,   32'h77,       32'h0,        FF,       32'h45,   32'h0));
        vecs.push_back(mk(LD, SZ_W,   32'h44,   32'h0,        32'hA5C30044, F0,       32'h45,   32'h0));
        vecs.push_back(mk(ST, SZ_W,   TOHOST,   32'h1,        32'h0,        TV | HH,  32'h45,   32'h1));
        vecs.push_back(mk(ID, SZ_W,   32'h0,    32'h0,        32'h0,        HH,       32'h45,   32'h1));
        vecs.push_back(mk(LD, SZ_W,   TOHOST,   32'h0,        32'h1,        HH,       32'h45,   32'h1));
        vecs.push_back(mk(ST, SZ_B,   32'hF001, 32'hFF,       32'h0,        FF | HH,  32'hF001, 32'h1));
        vecs.push_back(mk(ST, SZ_W,   TOHOST,   32'h2,        32'h0,        TV | HH,  32'hF001, 32'h2));
        vecs.push_back(mk(RS, SZ_W,   32'h10,   32'h0,        32'h0,        F0,       32'h0,    32'h0));
        vecs.push_back(mk(ID, SZ_W,   32'h0,    32'h0,        32'h0,        F0,       32'h0,    32'h0));
        vecs.push_back(mk(ST, SZ_B,   32'hF001, 32'h77,       32'h0,        FF,       32'hF001, 32'h0));
        vecs.push_back(mk(SL, SZ_W,   32'h50,   32'h12345678, 32'h0,        F0,       32'hF001, 32'h0));
        vecs.push_back(mk(LD, SZ_W,   32'h50,   32'h0,        32'h12345678, F0,       32'hF001, 32'h0));
        vecs.push_back(mk(ST, SZ_W,   32'h54,   32'h11223344, 32'h0,        F0,       32'hF001, 32'h0));
        vecs.push_back(mk(LD, SZ_HU,  32'h56,   32'h0,        32'h00001122, F0,       32'hF001, 32'h0));
        vecs.push_back(mk(LD, SZ_B,   32'h54,   32'h0,        32'h00000044, F0,       32'hF001, 32'h0));
        vecs.push_back(mk(LD, SZ_H,   32'h54,   32'h0,        32'h00003344, F0,       32'hF001, 32'h0));
        vecs.push_back(mk(LD, SZ_B,   32'h57,   32'h0,        32'h00000011, F0,       32'hF001, 32'h0));
        vecs.push_back(mk(LD, SZ_W,   32'h42,   32'h0,        32'h0,        FF,       32'h42,   32'h0));
        vecs.push_back(mk(ST, SZ_W,   32'h4010, 32'hBADC0FFE, 32'h0,        F0,       32'h42,   32'h0));
        vecs.push_back(mk(LD, SZ_W,   32'h10,   32'h0,        32'hBADC0FFE, F0,       32'h42,   32'h0));
        vecs.push_back(mk(ST, SZ_W,   TOHOST,   32'h10,       32'h0,        TV,       32'h42,   32'h10));

        foreach (vecs[i]) begin
            modelStep(vecs[i].op[2], vecs[i].op[1], vecs[i].op[0], vecs[i].size, vecs[i].addr, vecs[i].wdata);
            applyStimulus(vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].wdata);
            checkOutput(vecs[i].expRdata, vecs[i].expFlags[2], vecs[i].expFaultAddr,
                        vecs[i].expFlags[1], vecs[i].expTohost, vecs[i].expFlags[0]);
        end

        // Halt must hold across idle cycles and drop only on reset.
        modelCycle(ST, SZ_W, TOHOST, 32'h3);
        for (int k = 0; k < 3; k++) modelCycle(ID, SZ_W, 32'h0, 32'h0);
        modelCycle(LD, SZ_W, TOHOST, 32'h0);
        modelCycle(RS, SZ_W, 32'h0, 32'h0);
        modelCycle(ID, SZ_W, 32'h0, 32'h0);

        for (int k = 0; k < 400; k++) begin
            logic [2:0]  op, sz;
            logic [31:0] a, wd;
            op = {($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            if ($urandom_range(0, 4) == 0) sz = 3'($urandom_range(0, 7));
            else begin
                case ($urandom_range(0, 4))
                    0:       sz = SZ_B;
                    1:       sz = SZ_H;
                    2:       sz = SZ_W;
                    3:       sz = SZ_BU;
                    default: sz = SZ_HU;
                endcase
            end
            if ($urandom_range(0, 7) == 0) a = TOHOST + $urandom_range(0, 3);
            else a = $urandom_range(0, 255) + ($urandom_range(0, 3) << 14);
            if ($urandom_range(0, 9) < 7) begin
                if (sz[1:0] == 2'b10) a = a & ~32'h3;
                else if (sz[1:0] == 2'b01) a = a & ~32'h1;
            end
            wd = $urandom;
            modelCycle(op, sz, a, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
